// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types and constants for the two-master SPI flash pin arbiter.
// Covers state encodings, idle pin levels, the pin bundle and the round-robin pick.
package spi_bus_arbiter_pkg;

    localparam int unsigned HOLD_CNT_W = 24;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN   = 2'd1,
        ARB_GUARD = 2'd2
    } arb_state_t;

    // Master-driven flash pins travel together through the mux
    typedef struct packed {
        logic cs_b;
        logic sck;
        logic mosi;
    } spi_pins_t;

    localparam spi_pins_t IDLE_PINS = '{cs_b: 1'b1, sck: 1'b0, mosi: 1'b0};
    localparam logic      IDLE_MISO = 1'b1;

    // Winner among effective requests; a tie goes to whoever did not own last
    function automatic logic rr_pick(input logic [1:0] eff_req, input logic last_owner);
        logic pick;
        case (eff_req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_owner;
            default: pick = 1'b0;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_mux.sv
// Combinational 2:1 SPI pin mux between two masters and the flash.
// Forcing idle parks the flash pins and returns idle miso to both masters.
module spi_bus_mux
    import spi_bus_arbiter_pkg::*;
(
    input  logic      i_force_idle,
    input  logic      i_sel,
    input  spi_pins_t i_m0_pins,
    input  spi_pins_t i_m1_pins,
    input  logic      i_flash_miso,
    output spi_pins_t o_flash_pins_c,
    output logic      o_m0_miso_c,
    output logic      o_m1_miso_c
);

    always_comb begin
        o_flash_pins_c = IDLE_PINS;
        o_m0_miso_c    = IDLE_MISO;
        o_m1_miso_c    = IDLE_MISO;
        if (!i_force_idle) begin
            if (i_sel) begin
                o_flash_pins_c = i_m1_pins;
                o_m1_miso_c    = i_flash_miso;
            end else begin
                o_flash_pins_c = i_m0_pins;
                o_m0_miso_c    = i_flash_miso;
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Arbitrates the SPI flash pins between the USB bridge (master 0) and an on-chip
// client (master 1) with round-robin grant, CS-high guard time and optional hold timeout.
module spi_bus_arbiter
    import spi_bus_arbiter_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES    = 4,
    parameter int unsigned MAX_HOLD_CYCLES = 0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    input  logic       i_m0_spi_cs_b,
    input  logic       i_m0_spi_sck,
    input  logic       i_m0_spi_mosi,
    output logic       o_m0_spi_miso,
    input  logic       i_m1_spi_cs_b,
    input  logic       i_m1_spi_sck,
    input  logic       i_m1_spi_mosi,
    output logic       o_m1_spi_miso,
    output logic       o_spi_cs_b,
    output logic       o_spi_sck,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso,
    output logic       o_busy,
    output logic       o_hold_timeout
);

    // A zero guard still spends one idle cycle between owners
    localparam int unsigned GUARD_LOAD = (GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1;
    localparam int unsigned GUARD_W    = (GUARD_LOAD < 2) ? 1 : $clog2(GUARD_LOAD + 1);
    localparam logic        HOLD_EN    = (MAX_HOLD_CYCLES != 0);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD_CYCLES == 0) ? '0 : HOLD_CNT_W'(MAX_HOLD_CYCLES - 1);

    arb_state_t            r_state;
    logic                  r_owner;
    logic                  r_last_owner;
    logic [GUARD_W-1:0]    r_guard_cnt;
    logic [HOLD_CNT_W-1:0] r_hold_cnt;
    logic [1:0]            r_drop_wait;
    logic [1:0]            r_gnt;
    logic                  r_busy;
    logic                  r_hold_timeout;

    logic [1:0] w_eff_req;
    logic       w_pick;
    logic       w_owner_req;
    logic       w_owner_cs_b;
    logic       w_release;
    logic       w_revoke;
    logic [1:0] w_drop_set;
    spi_pins_t  w_m0_pins;
    spi_pins_t  w_m1_pins;
    spi_pins_t  w_flash_pins;

    assign w_eff_req    = i_req & ~r_drop_wait;
    assign w_pick       = rr_pick(w_eff_req, r_last_owner);
    assign w_owner_req  = i_req[r_owner];
    assign w_owner_cs_b = r_owner ? i_m1_spi_cs_b : i_m0_spi_cs_b;
    // Normal release only between frames, i.e. with the owner's chip select high
    assign w_release    = ~w_owner_req & w_owner_cs_b;
    assign w_revoke     = HOLD_EN && (r_hold_cnt == HOLD_LAST);

    always_comb begin
        w_drop_set = 2'b00;
        if (r_state == ARB_OWN && !w_release && w_revoke) begin
            w_drop_set = r_owner ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ARB_IDLE;
            r_owner        <= 1'b0;
            r_last_owner   <= 1'b1;
            r_guard_cnt    <= '0;
            r_hold_cnt     <= '0;
            r_drop_wait    <= 2'b00;
            r_gnt          <= 2'b00;
            r_busy         <= 1'b0;
            r_hold_timeout <= 1'b0;
        end else begin
            r_hold_timeout <= 1'b0;
            // A revoked master stays masked until it lets go of its request
            r_drop_wait    <= (r_drop_wait | w_drop_set) & i_req;
            case (r_state)
                ARB_IDLE: begin
                    if (|w_eff_req) begin
                        r_owner    <= w_pick;
                        r_gnt      <= w_pick ? 2'b10 : 2'b01;
                        r_hold_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ARB_OWN;
                    end
                end
                ARB_OWN: begin
                    if (w_release || w_revoke) begin
                        r_gnt          <= 2'b00;
                        r_last_owner   <= r_owner;
                        r_guard_cnt    <= GUARD_W'(GUARD_LOAD);
                        r_hold_timeout <= ~w_release;
                        r_state        <= ARB_GUARD;
                    end else if (r_hold_cnt != '1) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_CNT_W'(1);
                    end
                end
                ARB_GUARD: begin
                    if (r_guard_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= ARB_IDLE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt - GUARD_W'(1);
                    end
                end
                default: begin
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign w_m0_pins = '{cs_b: i_m0_spi_cs_b, sck: i_m0_spi_sck, mosi: i_m0_spi_mosi};
    assign w_m1_pins = '{cs_b: i_m1_spi_cs_b, sck: i_m1_spi_sck, mosi: i_m1_spi_mosi};

    // Pin path is unpipelined: the bridge toggles sck every cycle
    spi_bus_mux u_mux (
        .i_force_idle   (r_state != ARB_OWN),
        .i_sel          (r_owner),
        .i_m0_pins      (w_m0_pins),
        .i_m1_pins      (w_m1_pins),
        .i_flash_miso   (i_spi_miso),
        .o_flash_pins_c (w_flash_pins),
        .o_m0_miso_c    (o_m0_spi_miso),
        .o_m1_miso_c    (o_m1_spi_miso)
    );

    assign o_spi_cs_b     = w_flash_pins.cs_b;
    assign o_spi_sck      = w_flash_pins.sck;
    assign o_spi_mosi     = w_flash_pins.mosi;
    assign o_gnt          = r_gnt;
    assign o_busy         = r_busy;
    assign o_hold_timeout = r_hold_timeout;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench: three arbiter configurations share one stimulus stream and are
// compared every cycle against an ownership-timeline model, plus directed timing checks.
module tb_spi_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] cs_b;
    logic [1:0] sck;
    logic [1:0] mosi;
    logic       miso;

    logic [2:0][1:0] gnt_o;
    logic [2:0]      busy_o, to_o, fcs_o, fsck_o, fmosi_o, m0miso_o, m1miso_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: owner -1 = none; guard = GUARD cycles still to spend; held = OWN cycles elapsed
    int         m_owner[3];
    int         m_guard[3];
    int         m_held[3];
    int         m_last[3];
    logic [1:0] m_drop[3];
    logic       m_to[3];

    always #5 clk = ~clk;

    // Instance 0: defaults; 1: hold timeout of 100; 2: zero guard
    for (genvar g = 0; g < 3; g++) begin : g_dut
        spi_bus_arbiter #(
            .GUARD_CYCLES    ((g == 2) ? 0 : 4),
            .MAX_HOLD_CYCLES ((g == 1) ? 100 : 0)
        ) u_dut (
            .i_clk          (clk),
            .i_reset        (rst),
            .i_req          (req),
            .o_gnt          (gnt_o[g]),
            .i_m0_spi_cs_b  (cs_b[0]),
            .i_m0_spi_sck   (sck[0]),
            .i_m0_spi_mosi  (mosi[0]),
            .o_m0_spi_miso  (m0miso_o[g]),
            .i_m1_spi_cs_b  (cs_b[1]),
            .i_m1_spi_sck   (sck[1]),
            .i_m1_spi_mosi  (mosi[1]),
            .o_m1_spi_miso  (m1miso_o[g]),
            .o_spi_cs_b     (fcs_o[g]),
            .o_spi_sck      (fsck_o[g]),
            .o_spi_mosi     (fmosi_o[g]),
            .i_spi_miso     (miso),
            .o_busy         (busy_o[g]),
            .o_hold_timeout (to_o[g])
        );
    end

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic model_step(input int i);
        int         gc;
        int         mh;
        logic [1:0] setb;
        logic [1:0] eff;
        gc      = (i == 2) ? 0 : 4;
        mh      = (i == 1) ? 100 : 0;
        setb    = 2'b00;
        m_to[i] = 1'b0;
        if (rst) begin
            m_owner[i] = -1;
            m_guard[i] = 0;
            m_held[i]  = 0;
            m_last[i]  = 1;
            m_drop[i]  = 2'b00;
            return;
        end
        if (m_owner[i] >= 0) begin
            m_held[i]++;
            if (!req[m_owner[i]] && cs_b[m_owner[i]]) begin
                m_last[i]  = m_owner[i];
                m_owner[i] = -1;
                m_guard[i] = (gc == 0) ? 1 : gc;
            end else if (mh != 0 && m_held[i] == mh) begin
                m_to[i]             = 1'b1;
                setb[m_owner[i]]    = 1'b1;
                m_last[i]           = m_owner[i];
                m_owner[i]          = -1;
                m_guard[i]          = (gc == 0) ? 1 : gc;
            end
        end else if (m_guard[i] > 0) begin
            m_guard[i]--;
        end else begin
            eff = req & ~m_drop[i];
            if (eff == 2'b11)      m_owner[i] = 1 - m_last[i];
            else if (eff == 2'b10) m_owner[i] = 1;
            else if (eff == 2'b01) m_owner[i] = 0;
            if (eff != 2'b00) m_held[i] = 0;
        end
        m_drop[i] = (m_drop[i] | setb) & req;
    endtask

    task automatic check_pins(input int i);
        int o;
        o = m_owner[i];
        chk("spi_cs_b", i, 32'(fcs_o[i]),    32'((o >= 0) ? cs_b[o] : 1'b1));
        chk("spi_sck",  i, 32'(fsck_o[i]),   32'((o >= 0) ? sck[o]  : 1'b0));
        chk("spi_mosi", i, 32'(fmosi_o[i]),  32'((o >= 0) ? mosi[o] : 1'b0));
        chk("m0_miso",  i, 32'(m0miso_o[i]), 32'((o == 0) ? miso : 1'b1));
        chk("m1_miso",  i, 32'(m1miso_o[i]), 32'((o == 1) ? miso : 1'b1));
    endtask

    task automatic check_regs(input int i);
        logic [1:0] eg;
        eg = (m_owner[i] < 0) ? 2'b00 : ((m_owner[i] == 0) ? 2'b01 : 2'b10);
        chk("gnt",          i, 32'(gnt_o[i]), 32'(eg));
        chk("busy",         i, 32'(busy_o[i]), 32'((m_owner[i] >= 0) || (m_guard[i] > 0)));
        chk("hold_timeout", i, 32'(to_o[i]),  32'(m_to[i]));
    endtask

    // One clock: pins checked against new inputs, then registers after the edge
    task automatic cycle();
        #1;
        for (int i = 0; i < 3; i++) check_pins(i);
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_regs(i);
            check_pins(i);
        end
    endtask

    initial begin
        int n;
        rst  = 1'b1;
        req  = 2'b00;
        cs_b = 2'b11;
        sck  = 2'b00;
        mosi = 2'b00;
        miso = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_regs(i);
            check_pins(i);
        end
        chk("reset_gnt", 0, 32'(gnt_o[0]), 32'(2'b00));
        chk("reset_cs_b", 0, 32'(fcs_o[0]), 32'(1'b1));
        rst = 1'b0;
        cycle();

        // Single grant, 16 sck toggles with flash miso high, then release
        req = 2'b01;
        cycle();
        chk("single_gnt", 0, 32'(gnt_o[0]), 32'(2'b01));
        cs_b[0] = 1'b0;
        miso    = 1'b1;
        for (int k = 0; k < 16; k++) begin
            sck[0]  = ~sck[0];
            mosi[0] = 1'($urandom_range(1));
            cycle();
        end
        chk("single_m1_miso", 0, 32'(m1miso_o[0]), 32'(1'b1));
        req[0]  = 1'b0;
        cs_b[0] = 1'b1;
        cycle();
        chk("single_release", 0, 32'(gnt_o[0]), 32'(2'b00));
        repeat (4) cycle();
        chk("single_guard_done", 0, 32'(busy_o[0]), 32'(1'b0));
        repeat (2) cycle();

        // Tie after reset: master 0 first, master 1 five edges after release
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req = 2'b11;
        cycle();
        chk("tie_gnt", 0, 32'(gnt_o[0]), 32'(2'b01));
        cs_b[0] = 1'b0;
        repeat (3) cycle();
        req[0]  = 1'b0;
        cs_b[0] = 1'b1;
        cycle();
        n = 0;
        while (gnt_o[0] !== 2'b10 && n < 20) begin
            if (n == 1) req[0] = 1'b1;
            cycle();
            n++;
        end
        chk("tie_regrant_edges", 0, 32'(n), 32'd5);
        cs_b[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sck[1]  = ~sck[1];
            mosi[1] = 1'($urandom_range(1));
            miso    = 1'($urandom_range(1));
            cycle();
        end
        req[1]  = 1'b0;
        cs_b[1] = 1'b1;
        sck[1]  = 1'b0;
        cycle();
        n = 0;
        while (gnt_o[0] !== 2'b01 && n < 20) begin
            cycle();
            n++;
        end
        chk("rr_back_to_m0_edges", 0, 32'(n), 32'd5);

        // Release deferred while the frame is open
        cs_b[0] = 1'b0;
        cycle();
        req[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sck[0] = ~sck[0];
            cycle();
            chk("deferred_gnt", 0, 32'(gnt_o[0]), 32'(2'b01));
        end
        cs_b[0] = 1'b1;
        sck[0]  = 1'b0;
        cycle();
        chk("deferred_release", 0, 32'(gnt_o[0]), 32'(2'b00));
        repeat (6) cycle();

        // Forced revocation on instance 1
        req[0]  = 1'b1;
        cs_b[0] = 1'b0;
        cycle();
        chk("revoke_gnt", 1, 32'(gnt_o[1]), 32'(2'b01));
        n = 0;
        while (to_o[1] !== 1'b1 && n < 150) begin
            sck[0] = ~sck[0];
            cycle();
            n++;
        end
        chk("revoke_at_own_cycle", 1, 32'(n), 32'd100);
        sck[0] = 1'b1;
        cycle();
        chk("revoke_cs_idle", 1, 32'(fcs_o[1]), 32'(1'b1));
        chk("revoke_pulse_width", 1, 32'(to_o[1]), 32'(1'b0));
        repeat (20) cycle();
        chk("revoke_no_regrant", 1, 32'(gnt_o[1]), 32'(2'b00));
        req[0] = 1'b0;
        cycle();
        req[0] = 1'b1;
        cycle();
        chk("revoke_rerequest", 1, 32'(gnt_o[1]), 32'(2'b01));
        repeat (3) cycle();
        req[0]  = 1'b0;
        cs_b[0] = 1'b1;
        sck[0]  = 1'b0;
        repeat (8) cycle();

        // Reset in the middle of a master 1 transfer
        req = 2'b10;
        cycle();
        cs_b[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sck[1] = ~sck[1];
            cycle();
        end
        sck[1] = 1'b1;
        rst    = 1'b1;
        cycle();
        chk("rst_mid_gnt", 0, 32'(gnt_o[0]), 32'(2'b00));
        chk("rst_mid_cs_b", 0, 32'(fcs_o[0]), 32'(1'b1));
        chk("rst_mid_sck", 0, 32'(fsck_o[0]), 32'(1'b0));
        rst  = 1'b0;
        req  = 2'b11;
        cs_b = 2'b11;
        sck  = 2'b00;
        cycle();
        chk("rst_tie_gnt", 0, 32'(gnt_o[0]), 32'(2'b01));

        // Zero guard: one GUARD cycle, then IDLE, then the waiting master
        req = 2'b10;
        cycle();
        chk("g0_release", 2, 32'(gnt_o[2]), 32'(2'b00));
        n = 0;
        while (gnt_o[2] !== 2'b10 && n < 20) begin
            cycle();
            n++;
        end
        chk("g0_regrant_edges", 2, 32'(n), 32'd2);
        req = 2'b00;
        repeat (8) cycle();

        // Randomised traffic
        for (int k = 0; k < 2000; k++) begin
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(7) == 0) req[b] = ~req[b];
                if ($urandom_range(3) == 0) cs_b[b] = ~cs_b[b];
                sck[b]  = 1'($urandom_range(1));
                mosi[b] = 1'($urandom_range(1));
            end
            miso = 1'($urandom_range(1));
            rst  = ($urandom_range(499) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Shares the single SPI flash pin set between two SPI masters: master 0 is the USB SPI bridge endpoint, and master 1 is an on-chip flash client such as the boot-metadata reader. It sits between the masters and the top-level `spi_cs_b`/`spi_sck`/`spi_mosi`/`spi_miso` pins. It grants ownership with a request/grant handshake, enforces a chip-select-high guard time between owners, and can optionally revoke a grant that is held too long.

## Interface
- `GUARD_CYCLES`, default 4: bus-idle cycles between owners; a value of 0 behaves as 1.
- `MAX_HOLD_CYCLES`, default 0: cycles a grant may be held before forced revocation; 0 disables revocation. Must be < 2^24.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `req` in 2: per-master bus request (bit 0 = master 0).
- `gnt` out 2: registered, one-hot or zero ownership grant.
- `m0_spi_cs_b`, `m0_spi_sck`, `m0_spi_mosi` in 1 each: master 0 pins.
- `m0_spi_miso` out 1: flash data to master 0.
- `m1_spi_cs_b`, `m1_spi_sck`, `m1_spi_mosi` in 1 each: master 1 pins.
- `m1_spi_miso` out 1: flash data to master 1.
- `spi_cs_b`, `spi_sck`, `spi_mosi` out 1 each: flash pins.
- `spi_miso` in 1: flash data.
- `busy` out 1: high in OWN and GUARD.
- `hold_timeout` out 1: one-cycle pulse on forced revocation.

## Operation
- **States:** IDLE, OWN, GUARD. Registers: `owner` (1 bit), `last_owner` (1 bit, reset 1), `guard_cnt`, `hold_cnt` (24 bits), `drop_wait[1:0]`.
- **IDLE.** The effective request is `req & ~drop_wait`.
  - Nothing requested: stay in IDLE.
  - One master requesting: grant it.
  - Both requesting: grant `~last_owner` (round-robin).
  - On a grant: go to OWN, set `gnt` one-hot, and clear `hold_cnt`.
- **OWN.** The owner's cs_b/sck/mosi drive the flash pins. `spi_miso` is routed to the owner; the non-owner's miso reads 1.
  - Normal release: when the owner's `req`=0 and its `cs_b`=1 in the same cycle, clear `gnt`, set `last_owner`=`owner`, and go to GUARD.
  - If `req`=0 while `cs_b`=0, stay in OWN; the flash transaction is never cut mid-frame by a normal release.
  - `hold_cnt` increments every OWN cycle and saturates.
  - Forced revocation: when `MAX_HOLD_CYCLES`≠0 and `hold_cnt`==`MAX_HOLD_CYCLES`-1, clear `gnt`, pulse `hold_timeout`, set `drop_wait[owner]`, update `last_owner`, and go to GUARD. The bus is forced idle from the next cycle regardless of the owner's pins.
- **GUARD.** Pins are idle. `guard_cnt` loads max(`GUARD_CYCLES`,1)-1 on entry and decrements; go to IDLE when it reaches 0.
- **`drop_wait`:** bit n clears in any cycle where `req[n]`=0. A revoked master must drop `req` before it is considered again.
- **Idle pin values** (IDLE, GUARD, reset): `spi_cs_b`=1, `spi_sck`=0, `spi_mosi`=0; both master miso outputs = 1.
- **Non-owner pins:** ignored; a non-owner's `req` is held pending.
- **Reset values:**
  - state IDLE, `gnt`=0, `busy`=0, `hold_timeout`=0
  - `last_owner`=1, so master 0 wins the first tie
  - `drop_wait`=0
  - pins idle
- **Reset mid-OWN:** the bus goes idle on the cycle after reset is sampled; the pending transaction is abandoned.

## Timing
- `req` rising at edge N produces `gnt` high after edge N+1 (1-cycle latency). Flash pins follow the owner starting in that same cycle.
- Pin mux is combinational from registered state/`owner`: zero-cycle pass-through on the cs_b/sck/mosi/miso paths. The bridge toggles sck every cycle, so no pipelining is allowed here.
- Release condition seen at edge N: `gnt`=0 after N+1. The next grant comes at the earliest `GUARD_CYCLES`+1 edges later (GUARD plus one IDLE cycle).
- `hold_timeout` is high for exactly the one cycle following the revoking edge.
- **Simultaneous events:**
  - The owner releasing while the other master requests: the other master is served after GUARD.
  - Both masters rising in the same cycle: the round-robin rule applies.

## Structure
- Shared package constants: state encodings `ARB_IDLE`/`ARB_OWN`/`ARB_GUARD`, the idle pin values, and `HOLD_CNT_W`=24.
- One sub-module is natural: `spi_bus_mux`, a purely combinational 2:1 pin mux with an idle-force input. The FSM, counters and `drop_wait` stay in `spi_bus_arbiter`.

## Test plan
- **Single grant:** `req`=01 at cycle 0 → `gnt`=01 at cycle 1. Toggle m0 sck 16 times with `spi_miso`=1 → m0 sees miso=1 and m1 sees 1. Release → `gnt`=00 at cycle N+1, and `busy` low after 4 GUARD cycles.
- **Tie after reset:** `req`=11 → `gnt`=01. Master 0 releases → `gnt`=10 exactly 5 edges after `gnt` dropped (`GUARD_CYCLES`=4). Master 0 re-requests meanwhile → it is served after master 1.
- **Release deferred:** the owner drops `req` with `cs_b`=0 for 10 cycles → `gnt` stays high. `cs_b` rises → `gnt`=0 the next cycle.
- **Forced revocation** (`MAX_HOLD_CYCLES`=100): the owner holds `req`/`cs_b`=0 → `hold_timeout` pulses at OWN cycle 100, `spi_cs_b`=1 from then, and there is no re-grant while `req` stays high. `req` 0→1 → granted after guard.
- **Reset mid-OWN:** assert `reset` during an m1 transfer → next cycle `gnt`=00, `spi_cs_b`=1, `spi_sck`=0. After reset, `req`=11 → `gnt`=01.
- **GUARD_CYCLES=0:** release → exactly 1 GUARD cycle, then IDLE, then grant (2 edges).
